// File: rtl/kws_detector_pkg.sv
// Shared types and defaults for the keyword-spotting decision stage.
package kws_pkg;

    // Decision FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_REFRACT = 2'd2
    } kws_state_t;

    // Smallest index width able to address n keywords (never below 1 bit).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int NUM_KEYWORDS_DEF = 10;
    localparam int IDX_BITS_DEF     = idx_width(NUM_KEYWORDS_DEF);

endpackage

// File: rtl/kws_onehot_enc.sv
// Strict one-hot encoder: hit only when exactly one bit of vec is set.
module kws_onehot_enc #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic seen_s;
    logic multi_s;

    // Scan for the first set bit and flag any second set bit as multi-hot.
    always_comb begin
        seen_s  = 1'b0;
        multi_s = 1'b0;
        idx     = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (vec[i] && seen_s) begin
                multi_s = 1'b1;
            end else if (vec[i]) begin
                seen_s = 1'b1;
                idx    = IDX_W'(i);
            end else begin
                multi_s = multi_s;
            end
        end
        hit = seen_s & ~multi_s;
    end

endmodule

// File: rtl/kws_detector.sv
// Temporal confirmation, refractory suppression and single-entry output slot
// for the per-frame keyword classifier result.
module kws_detector
    import kws_pkg::*;
#(
    parameter int NUM_KEYWORDS = NUM_KEYWORDS_DEF,
    parameter int IDX_BITS     = IDX_BITS_DEF,
    parameter int CNT_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_KEYWORDS-1:0] kws_result,
    input  logic                    kws_valid,
    input  logic [3:0]              cfg_hit_count,
    input  logic [7:0]              cfg_refractory,
    input  logic [NUM_KEYWORDS-1:0] cfg_kw_mask,
    input  logic                    clear,
    output logic                    det_valid,
    output logic [IDX_BITS-1:0]     det_keyword,
    input  logic                    det_ready,
    output logic                    det_overflow,
    output logic [CNT_BITS-1:0]     det_count
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    kws_state_t              state_r, state_n;
    logic [IDX_BITS-1:0]     cand_r, cand_n;
    logic [3:0]              run_r, run_n;
    logic [7:0]              ref_cnt_r, ref_cnt_n;
    logic                    det_valid_r, det_valid_n;
    logic [IDX_BITS-1:0]     det_keyword_r, det_keyword_n;
    logic                    det_overflow_r, det_overflow_n;
    logic [CNT_BITS-1:0]     det_count_r, det_count_n;

    logic [NUM_KEYWORDS-1:0] masked_s;
    logic                    hit_s;
    logic [IDX_BITS-1:0]     hit_idx_s;
    logic [3:0]              eff_hits_s;
    logic [3:0]              run_inc_s;
    logic                    fire_s;
    logic [IDX_BITS-1:0]     fire_idx_s;

    assign masked_s   = kws_result & cfg_kw_mask;
    assign eff_hits_s = (cfg_hit_count == 4'd0) ? 4'd1 : cfg_hit_count;
    assign run_inc_s  = run_r + 4'd1;

    kws_onehot_enc #(
        .N     (NUM_KEYWORDS),
        .IDX_W (IDX_BITS)
    ) u_enc (
        .vec (masked_s),
        .hit (hit_s),
        .idx (hit_idx_s)
    );

    // Decision FSM: candidate tracking, fire generation and refractory countdown.
    always_comb begin
        state_n    = state_r;
        cand_n     = cand_r;
        run_n      = run_r;
        ref_cnt_n  = ref_cnt_r;
        fire_s     = 1'b0;
        fire_idx_s = cand_r;
        case (state_r)
            ST_IDLE: begin
                if (kws_valid && hit_s) begin
                    cand_n     = hit_idx_s;
                    run_n      = 4'd1;
                    fire_idx_s = hit_idx_s;
                    if (eff_hits_s == 4'd1) begin
                        fire_s    = 1'b1;
                        state_n   = ST_REFRACT;
                        ref_cnt_n = cfg_refractory;
                    end else begin
                        state_n = ST_TRACK;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (kws_valid && hit_s && (hit_idx_s == cand_r)) begin
                    run_n = run_inc_s;
                    // >= keeps a lowered live hit count from stranding the run.
                    if (run_inc_s >= eff_hits_s) begin
                        fire_s    = 1'b1;
                        state_n   = ST_REFRACT;
                        ref_cnt_n = cfg_refractory;
                    end else begin
                        state_n = ST_TRACK;
                    end
                end else if (kws_valid && hit_s) begin
                    cand_n = hit_idx_s;
                    run_n  = 4'd1;
                end else if (kws_valid) begin
                    state_n = ST_IDLE;
                    run_n   = 4'd0;
                end else begin
                    state_n = ST_TRACK;
                end
            end
            ST_REFRACT: begin
                if (ref_cnt_r == 8'd0) begin
                    state_n = ST_IDLE;
                end else if (kws_valid) begin
                    ref_cnt_n = ref_cnt_r - 8'd1;
                    if (ref_cnt_r == 8'd1) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_REFRACT;
                    end
                end else begin
                    state_n = ST_REFRACT;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                run_n     = 4'd0;
                ref_cnt_n = 8'd0;
            end
        endcase
    end

    // Output slot: load on fire when free or being drained, else record overflow.
    always_comb begin
        det_valid_n    = det_valid_r;
        det_keyword_n  = det_keyword_r;
        det_overflow_n = det_overflow_r;
        det_count_n    = det_count_r;
        if (fire_s && (!det_valid_r || det_ready)) begin
            det_valid_n   = 1'b1;
            det_keyword_n = fire_idx_s;
            if (det_count_r == CNT_MAX) begin
                det_count_n = det_count_r;
            end else begin
                det_count_n = det_count_r + CNT_ONE;
            end
        end else if (fire_s) begin
            det_overflow_n = 1'b1;
        end else if (det_valid_r && det_ready) begin
            det_valid_n = 1'b0;
        end else begin
            det_valid_n = det_valid_r;
        end
    end

    // FSM and counter registers with reset and soft clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cand_r    <= {IDX_BITS{1'b0}};
            run_r     <= 4'd0;
            ref_cnt_r <= 8'd0;
        end else if (clear) begin
            state_r   <= ST_IDLE;
            cand_r    <= {IDX_BITS{1'b0}};
            run_r     <= 4'd0;
            ref_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_n;
            cand_r    <= cand_n;
            run_r     <= run_n;
            ref_cnt_r <= ref_cnt_n;
        end
    end

    // Output slot and status registers with reset and soft clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            det_valid_r    <= 1'b0;
            det_keyword_r  <= {IDX_BITS{1'b0}};
            det_overflow_r <= 1'b0;
            det_count_r    <= {CNT_BITS{1'b0}};
        end else if (clear) begin
            det_valid_r    <= 1'b0;
            det_keyword_r  <= {IDX_BITS{1'b0}};
            det_overflow_r <= 1'b0;
            det_count_r    <= {CNT_BITS{1'b0}};
        end else begin
            det_valid_r    <= det_valid_n;
            det_keyword_r  <= det_keyword_n;
            det_overflow_r <= det_overflow_n;
            det_count_r    <= det_count_n;
        end
    end

    assign det_valid    = det_valid_r;
    assign det_keyword  = det_keyword_r;
    assign det_overflow = det_overflow_r;
    assign det_count    = det_count_r;

endmodule

// File: tb/tb_kws_detector.sv
// Directed bench for kws_detector.
module tb_kws_detector;
    import kws_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  kws_result;
    logic        kws_valid;
    logic [3:0]  cfg_hit_count;
    logic [7:0]  cfg_refractory;
    logic [9:0]  cfg_kw_mask;
    logic        clear;
    logic        det_valid;
    logic [3:0]  det_keyword;
    logic        det_ready;
    logic        det_overflow;
    logic [15:0] det_count;

    int n_cmp;
    int n_err;

    kws_detector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .kws_result     (kws_result),
        .kws_valid      (kws_valid),
        .cfg_hit_count  (cfg_hit_count),
        .cfg_refractory (cfg_refractory),
        .cfg_kw_mask    (cfg_kw_mask),
        .clear          (clear),
        .det_valid      (det_valid),
        .det_keyword    (det_keyword),
        .det_ready      (det_ready),
        .det_overflow   (det_overflow),
        .det_count      (det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One classifier strobe carrying keyword k (k > 9 sends an empty vector).
    task automatic frame(input int k);
        logic [9:0] v;
        v = 10'd0;
        if (k < 10) v[k] = 1'b1;
        kws_result = v;
        kws_valid  = 1'b1;
        step();
        kws_valid  = 1'b0;
        kws_result = 10'd0;
    endtask

    // One strobe with a raw vector.
    task automatic frame_raw(input logic [9:0] v);
        kws_result = v;
        kws_valid  = 1'b1;
        step();
        kws_valid  = 1'b0;
        kws_result = 10'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept();
        det_ready = 1'b1;
        step();
        det_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        kws_result = 10'd0;
        kws_valid = 1'b0;
        cfg_hit_count = 4'd3;
        cfg_refractory = 8'd0;
        cfg_kw_mask = 10'h3FF;
        clear = 1'b0;
        det_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(det_valid), 32'd0);
        chk("rst_kw", 32'(det_keyword), 32'd0);
        chk("rst_ovf", 32'(det_overflow), 32'd0);
        chk("rst_cnt", 32'(det_count), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: three frames of keyword 5
        frame(5);
        frame(5);
        chk("t1_no_early", 32'(det_valid), 32'd0);
        frame(5);
        chk("t1_valid", 32'(det_valid), 32'd1);
        chk("t1_kw", 32'(det_keyword), 32'd5);
        chk("t1_cnt", 32'(det_count), 32'd1);
        accept();
        chk("t1_accepted", 32'(det_valid), 32'd0);
        chk("t1_idle", 32'(dut.state_r), 32'(ST_IDLE));

        // 2: 2,2,7,7,7 fires only for 7
        frame(2); frame(2); frame(7); frame(7);
        chk("t2_no_fire2", 32'(det_valid), 32'd0);
        frame(7);
        chk("t2_valid", 32'(det_valid), 32'd1);
        chk("t2_kw", 32'(det_keyword), 32'd7);
        chk("t2_cnt", 32'(det_count), 32'd2);
        accept();

        // 3: refractory of 4 frames, consumer always ready
        cfg_refractory = 8'd4;
        det_ready = 1'b1;
        frame(1); frame(1); frame(1);
        chk("t3_fire", 32'(det_valid), 32'd1);
        chk("t3_cnt_a", 32'(det_count), 32'd3);
        for (int i = 0; i < 6; i++) frame(1);
        chk("t3_suppressed_v", 32'(det_valid), 32'd0);
        chk("t3_suppressed_c", 32'(det_count), 32'd3);
        frame(1);
        chk("t3_refire", 32'(det_valid), 32'd1);
        chk("t3_kw", 32'(det_keyword), 32'd1);
        chk("t3_cnt_b", 32'(det_count), 32'd4);
        for (int i = 0; i < 4; i++) frame(10);
        det_ready = 1'b0;
        cfg_refractory = 8'd0;
        chk("t3_idle", 32'(dut.state_r), 32'(ST_IDLE));
        chk("t3_drained", 32'(det_valid), 32'd0);

        // 4: overflow while slot held
        frame(3); frame(3); frame(3);
        chk("t4_kw3", 32'(det_keyword), 32'd3);
        step();
        frame(8); frame(8); frame(8);
        chk("t4_valid", 32'(det_valid), 32'd1);
        chk("t4_kw_stable", 32'(det_keyword), 32'd3);
        chk("t4_ovf", 32'(det_overflow), 32'd1);
        chk("t4_cnt", 32'(det_count), 32'd5);
        step();
        accept();
        chk("t4_drained", 32'(det_valid), 32'd0);
        chk("t4_cnt_after", 32'(det_count), 32'd5);
        chk("t4_ovf_sticky", 32'(det_overflow), 32'd1);

        // fire coinciding with acceptance
        frame(6); frame(6); frame(6);
        chk("fa_kw6", 32'(det_keyword), 32'd6);
        step();
        frame(9); frame(9);
        det_ready = 1'b1;
        frame(9);
        det_ready = 1'b0;
        chk("fa_valid", 32'(det_valid), 32'd1);
        chk("fa_kw9", 32'(det_keyword), 32'd9);
        chk("fa_cnt", 32'(det_count), 32'd7);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid", 32'(det_valid), 32'd0);
        chk("clr_ovf", 32'(det_overflow), 32'd0);
        chk("clr_cnt", 32'(det_count), 32'd0);

        // 5: none classifications
        frame_raw(10'b0000000011);
        chk("t5_multi", 32'(dut.state_r), 32'(ST_IDLE));
        frame_raw(10'd0);
        chk("t5_zero", 32'(dut.state_r), 32'(ST_IDLE));
        cfg_kw_mask = 10'h3EF;
        frame(4);
        chk("t5_masked", 32'(dut.state_r), 32'(ST_IDLE));
        frame(2); frame(2);
        chk("t5_track", 32'(dut.state_r), 32'(ST_TRACK));
        frame(4);
        chk("t5_reset_st", 32'(dut.state_r), 32'(ST_IDLE));
        chk("t5_reset_run", 32'(dut.run_r), 32'd0);
        frame(2); frame(2);
        chk("t5_no_det", 32'(det_valid), 32'd0);
        frame_raw(10'b0000000011);
        cfg_kw_mask = 10'h3FF;
        cfg_hit_count = 4'd0;
        frame(6);
        chk("hc0_valid", 32'(det_valid), 32'd1);
        chk("hc0_kw", 32'(det_keyword), 32'd6);
        chk("hc0_cnt", 32'(det_count), 32'd1);
        step();
        accept();
        cfg_hit_count = 4'd3;

        // 6: clear and reset mid-run
        frame(5); frame(5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_clr_run", 32'(dut.run_r), 32'd0);
        chk("t6_clr_cnt", 32'(det_count), 32'd0);
        frame(5);
        chk("t6_no_det", 32'(det_valid), 32'd0);
        frame(5);
        chk("t6_no_det2", 32'(det_valid), 32'd0);
        frame(5);
        chk("t6_fire", 32'(det_valid), 32'd1);
        chk("t6_kw", 32'(det_keyword), 32'd5);
        chk("t6_cnt", 32'(det_count), 32'd1);
        step();
        frame(7); frame(7);
        rst_n = 1'b0;
        step();
        chk("t6_rst_valid", 32'(det_valid), 32'd0);
        chk("t6_rst_kw", 32'(det_keyword), 32'd0);
        chk("t6_rst_ovf", 32'(det_overflow), 32'd0);
        chk("t6_rst_cnt", 32'(det_count), 32'd0);
        chk("t6_rst_st", 32'(dut.state_r), 32'(ST_IDLE));
        rst_n = 1'b1;
        frame(7);
        chk("t6_run_discarded", 32'(det_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
